// File: rtl/sfx_arbiter.sv
// sfx_arbiter: priority arbiter routing one of NUM_CH sound-effect generators to the speaker
// Ports: clk/reset (sync, active-high); trig: per-channel request levels (rising edge counts);
// ch_sound: generator bitstreams; ch_enable: one-hot enable of the playing generator;
// sound: routed speaker bit; active_ch: playing channel; busy: playing; done: natural-completion
// pulse; pending: queued requests not yet started.
module sfx_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int TIMER_W  = 24,
  parameter int DURATION = 12500000,
  parameter int PREEMPT  = 1,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] ch_sound,
  output logic [NUM_CH-1:0] ch_enable,
  output logic              sound,
  output logic [CH_W-1:0]   active_ch,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] pending
);
  typedef enum logic {IDLE, PLAY} state_t;
  localparam logic [TIMER_W-1:0] TLOAD = TIMER_W'(DURATION - 1);
  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [NUM_CH-1:0]   pending_q, pending_d, trig_prev_q, rise, cand;
  logic [CH_W-1:0]     active_ch_q, active_ch_d, win, rwin;
  logic                done_q, done_d;
  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) lowest = CH_W'(i);
  endfunction
  always_comb begin
    rise        = trig & ~trig_prev_q;
    cand        = pending_q | rise;
    win         = lowest(cand);
    rwin        = lowest(rise);
    state_d     = state_q;
    timer_d     = timer_q;
    active_ch_d = active_ch_q;
    pending_d   = pending_q | rise;
    done_d      = 1'b0;
    // Completion has priority over any rise landing on the same edge.
    if (state_q == IDLE || timer_q == '0) begin
      done_d  = state_q == PLAY;
      state_d = |cand ? PLAY : IDLE;
      if (|cand) begin
        active_ch_d = win;
        timer_d     = TLOAD;
        pending_d   = cand & ~(NUM_CH'(1) << win);
      end
    end else begin
      timer_d = timer_q - 1'b1;
      // A rise at or above the playing priority restarts/steals the slot; the loser is dropped.
      if (PREEMPT != 0 && |rise && rwin <= active_ch_q) begin
        active_ch_d = rwin;
        timer_d     = TLOAD;
        pending_d   = pending_q | (rise & ~(NUM_CH'(1) << rwin));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pending_q   <= '0;
      trig_prev_q <= '0;
      active_ch_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      trig_prev_q <= trig;
      active_ch_q <= active_ch_d;
      done_q      <= done_d;
    end
  end
  assign busy      = state_q == PLAY;
  assign active_ch = active_ch_q;
  assign done      = done_q;
  assign pending   = pending_q;
  assign ch_enable = (NUM_CH'(1) << active_ch_q) & {NUM_CH{busy}};
  assign sound     = busy & ch_sound[active_ch_q];
endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: directed table-driven bench for sfx_arbiter (PREEMPT=1 and PREEMPT=0 instances)
module tb_sfx_arbiter;
  logic       clk, reset;
  logic [3:0] trig, ch_sound;
  logic [3:0] en1, pend1, en0, pend0;
  logic [1:0] act1, act0;
  logic       snd1, busy1, done1, snd0, busy0, done0;
  int         n_cmp = 0, n_err = 0;
  typedef struct {
    logic       r;
    logic [3:0] t, cs;
    logic       b;
    logic [1:0] a;
    logic       d;
    logic [3:0] p;
  } vec_t;
  vec_t tbl[$];
  sfx_arbiter #(.NUM_CH(4), .TIMER_W(4), .DURATION(8), .PREEMPT(1)) u1 (
    .clk(clk), .reset(reset), .trig(trig), .ch_sound(ch_sound), .ch_enable(en1),
    .sound(snd1), .active_ch(act1), .busy(busy1), .done(done1), .pending(pend1));
  sfx_arbiter #(.NUM_CH(4), .TIMER_W(4), .DURATION(8), .PREEMPT(0)) u0 (
    .clk(clk), .reset(reset), .trig(trig), .ch_sound(ch_sound), .ch_enable(en0),
    .sound(snd0), .active_ch(act0), .busy(busy0), .done(done0), .pending(pend0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void v(input logic r, input logic [3:0] t, input logic [3:0] cs,
                            input logic b, input logic [1:0] a, input logic d, input logic [3:0] p);
    vec_t e;
    e.r = r; e.t = t; e.cs = cs; e.b = b; e.a = a; e.d = d; e.p = p;
    tbl.push_back(e);
  endfunction
  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, got, want);
    end
  endtask
  task automatic step(input logic r, input logic [3:0] t);
    reset = r;
    trig  = t;
    @(posedge clk);
    #1;
  endtask
  task automatic c0(input string nm, input logic b, input logic [1:0] a, input logic d, input logic [3:0] p);
    logic [3:0] one, ee;
    one = 4'b0001;
    ee  = b ? one << a : 4'b0000;
    chk({nm, "_busy"}, 0, {7'b0, busy0}, {7'b0, b});
    chk({nm, "_done"}, 0, {7'b0, done0}, {7'b0, d});
    chk({nm, "_pend"}, 0, {4'b0, pend0}, {4'b0, p});
    chk({nm, "_en"}, 0, {4'b0, en0}, {4'b0, ee});
    if (b) chk({nm, "_act"}, 0, {6'b0, act0}, {6'b0, a});
  endtask
  initial begin
    logic [3:0] one, exp_en;
    logic       exp_snd;
    one      = 4'b0001;
    reset    = 1'b1;
    trig     = '0;
    ch_sound = '0;
    v(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
    v(1, 4'b0100, 4'b1111, 0, 0, 0, 4'b0000);
    // trig already high at release counts as a rise; plays exactly 8 cycles
    v(0, 4'b0100, 4'b0100, 1, 2, 0, 4'b0000);
    for (int i = 0; i < 7; i++) v(0, 4'b0000, (i % 2) ? 4'b0100 : 4'b1011, 1, 2, 0, 4'b0000);
    v(0, 4'b0000, 4'b0100, 0, 2, 1, 4'b0000);
    v(0, 4'b0000, 4'b0100, 0, 2, 0, 4'b0000);
    // preemption by ch0 three cycles into ch2
    v(0, 4'b0100, 4'b0001, 1, 2, 0, 4'b0000);
    v(0, 4'b0100, 4'b0101, 1, 2, 0, 4'b0000);
    v(0, 4'b0100, 4'b0001, 1, 2, 0, 4'b0000);
    v(0, 4'b0101, 4'b0001, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 7; i++) v(0, 4'b0101, (i % 2) ? 4'b0001 : 4'b1110, 1, 0, 0, 4'b0000);
    v(0, 4'b0000, 4'b0001, 0, 0, 1, 4'b0000);
    v(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
    // retrigger of the playing channel extends play
    v(0, 4'b0010, 4'b0010, 1, 1, 0, 4'b0000);
    v(0, 4'b0000, 4'b0010, 1, 1, 0, 4'b0000);
    v(0, 4'b0000, 4'b0000, 1, 1, 0, 4'b0000);
    v(0, 4'b0010, 4'b0010, 1, 1, 0, 4'b0000);
    for (int i = 0; i < 7; i++) v(0, 4'b0000, 4'b0010, 1, 1, 0, 4'b0000);
    v(0, 4'b0000, 4'b0010, 0, 1, 1, 4'b0000);
    v(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000);
    // lower-priority rise queues, then starts back-to-back
    v(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0000);
    v(0, 4'b0011, 4'b0001, 1, 0, 0, 4'b0010);
    for (int i = 0; i < 6; i++) v(0, 4'b0011, 4'b0011, 1, 0, 0, 4'b0010);
    v(0, 4'b0011, 4'b0010, 1, 1, 1, 4'b0000);
    for (int i = 0; i < 7; i++) v(0, 4'b0011, 4'b1101, 1, 1, 0, 4'b0000);
    v(0, 4'b0000, 4'b0010, 0, 1, 1, 4'b0000);
    v(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000);
    // rise coinciding with timer expiry: completion first, then ch1 starts
    v(0, 4'b0100, 4'b0100, 1, 2, 0, 4'b0000);
    for (int i = 0; i < 7; i++) v(0, 4'b0100, 4'b0100, 1, 2, 0, 4'b0000);
    v(0, 4'b0110, 4'b0010, 1, 1, 1, 4'b0000);
    v(0, 4'b1110, 4'b0010, 1, 1, 0, 4'b1000);
    // reset mid-play discards pending, no done, sound muted
    v(1, 4'b1110, 4'b1111, 0, 0, 0, 4'b0000);
    v(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
    v(1, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000);
    v(0, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000);
    foreach (tbl[i]) begin
      reset    = tbl[i].r;
      trig     = tbl[i].t;
      ch_sound = tbl[i].cs;
      @(posedge clk);
      #1;
      exp_en  = tbl[i].b ? one << tbl[i].a : 4'b0000;
      exp_snd = tbl[i].b & tbl[i].cs[tbl[i].a];
      chk("busy", i, {7'b0, busy1}, {7'b0, tbl[i].b});
      chk("done", i, {7'b0, done1}, {7'b0, tbl[i].d});
      chk("pending", i, {4'b0, pend1}, {4'b0, tbl[i].p});
      chk("ch_enable", i, {4'b0, en1}, {4'b0, exp_en});
      chk("sound", i, {7'b0, snd1}, {7'b0, exp_snd});
      if (tbl[i].b || tbl[i].d) chk("active_ch", i, {6'b0, act1}, {6'b0, tbl[i].a});
    end
    // PREEMPT=0: no interruption, self-rise queues, back-to-back service
    step(1, 4'b0000); c0("p0_rst", 0, 0, 0, 4'b0000);
    step(0, 4'b1000); c0("p0_start", 1, 3, 0, 4'b0000);
    step(0, 4'b1000);
    step(0, 4'b1000);
    step(0, 4'b1001); c0("p0_nopreempt", 1, 3, 0, 4'b0001);
    step(0, 4'b0001);
    step(0, 4'b1001); c0("p0_selfpend", 1, 3, 0, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b1001); c0("p0_last", 1, 3, 0, 4'b1001);
    step(0, 4'b1001); c0("p0_ch3done", 1, 0, 1, 4'b1000);
    repeat (7) step(0, 4'b1001);
    c0("p0_ch0end", 1, 0, 0, 4'b1000);
    step(0, 4'b1001); c0("p0_b2b", 1, 3, 1, 4'b0000);
    repeat (7) step(0, 4'b1001);
    c0("p0_ch3end", 1, 3, 0, 4'b0000);
    step(0, 4'b0000); c0("p0_idle", 0, 3, 1, 4'b0000);
    step(0, 4'b0000); c0("p0_quiet", 0, 3, 0, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
